// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-port LSU arbiter.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DBG  = 1;

    // Store-type encodings understood by the LSU; carried through untouched.
    localparam logic [2:0] BMASK_BYTE = 3'b001;
    localparam logic [2:0] BMASK_HALF = 3'b010;
    localparam logic [2:0] BMASK_WORD = 3'b100;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner selection: round-robin or fixed priority to port 0.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] winner
);
    import lsu_arb_pkg::*;

    always_comb begin
        winner = '0;
        if (req[PORT_CORE] && req[PORT_DBG]) begin
            // On a tie the port that did not win last time goes first.
            if (fixed_prio || last_grant) winner[PORT_CORE] = 1'b1;
            else                          winner[PORT_DBG]  = 1'b1;
        end else begin
            winner = req;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU port between the core path (port 0) and debug/boot (port 1).
module lsu_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic [2:0]        i_bmask0,
    input  logic [2:0]        i_bmask1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_lsu_st_data,
    output logic              o_lsu_wren,
    output logic [2:0]        o_lsu_bmask,
    input  logic [DATA_W-1:0] i_lsu_ld_data,
    output logic [1:0]        o_grant,
    output logic              o_busy
);
    import lsu_arb_pkg::*;

    arb_state_t state_q, state_d;
    logic       last_grant;
    logic       is_store;
    logic [1:0] req;
    logic [1:0] winner;
    logic       fixed_prio;

    assign req        = {i_req1, i_req0};
    assign fixed_prio = (FIXED_PRIO != 0);

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .fixed_prio (fixed_prio),
        .winner     (winner)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_grant    <= 1'(PORT_DBG);
            is_store      <= 1'b0;
            o_ack0        <= 1'b0;
            o_ack1        <= 1'b0;
            o_rdata0      <= '0;
            o_rdata1      <= '0;
            o_lsu_addr    <= '0;
            o_lsu_st_data <= '0;
            o_lsu_wren    <= 1'b0;
            o_lsu_bmask   <= '0;
            o_grant       <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        if (winner[PORT_CORE]) begin
                            o_lsu_addr    <= i_addr0;
                            o_lsu_st_data <= i_wdata0;
                            o_lsu_bmask   <= i_bmask0;
                            o_lsu_wren    <= i_we0;
                            is_store      <= i_we0;
                        end else begin
                            o_lsu_addr    <= i_addr1;
                            o_lsu_st_data <= i_wdata1;
                            o_lsu_bmask   <= i_bmask1;
                            o_lsu_wren    <= i_we1;
                            is_store      <= i_we1;
                        end
                        o_grant    <= winner;
                        last_grant <= winner[PORT_DBG];
                        o_busy     <= 1'b1;
                    end
                end
                ACCESS: begin
                    o_lsu_wren <= 1'b0;
                    o_ack0     <= o_grant[PORT_CORE];
                    o_ack1     <= o_grant[PORT_DBG];
                    if (!is_store) begin
                        if (o_grant[PORT_CORE]) o_rdata0 <= i_lsu_ld_data;
                        else                    o_rdata1 <= i_lsu_ld_data;
                    end
                end
                RESP: begin
                    o_ack0  <= 1'b0;
                    o_ack1  <= 1'b0;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
                default: begin
                    o_lsu_wren <= 1'b0;
                    o_grant    <= '0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter; a second instance runs with fixed priority.
module tb_lsu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, lsu_ld;
    logic [2:0]  bmask0, bmask1;

    logic        ack0, ack1, wren, busy;
    logic [31:0] rdata0, rdata1, lsu_addr, st_data;
    logic [2:0]  lsu_bmask;
    logic [1:0]  grant;

    logic        f_ack0, f_ack1, f_wren, f_busy;
    logic [31:0] f_rdata0, f_rdata1, f_lsu_addr, f_st_data;
    logic [2:0]  f_lsu_bmask;
    logic [1:0]  f_grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .i_bmask0(bmask0), .i_bmask1(bmask1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_lsu_addr(lsu_addr), .o_lsu_st_data(st_data), .o_lsu_wren(wren),
        .o_lsu_bmask(lsu_bmask), .i_lsu_ld_data(lsu_ld),
        .o_grant(grant), .o_busy(busy)
    );

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fixed (
        .i_clk(clk), .i_reset(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .i_bmask0(bmask0), .i_bmask1(bmask1),
        .o_ack0(f_ack0), .o_ack1(f_ack1), .o_rdata0(f_rdata0), .o_rdata1(f_rdata1),
        .o_lsu_addr(f_lsu_addr), .o_lsu_st_data(f_st_data), .o_lsu_wren(f_wren),
        .o_lsu_bmask(f_lsu_bmask), .i_lsu_ld_data(lsu_ld),
        .o_grant(f_grant), .o_busy(f_busy)
    );

    task automatic do_reset();
        @(negedge clk);
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bmask0 = '0; bmask1 = '0; lsu_ld = '0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", ack1, ack0); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (busy !== 1'b0 || wren !== 1'b0) begin bad++; $display("FAIL reset_busy_wren got=%b%b exp=00", busy, wren); end
        total++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
        total++; if (lsu_addr !== 32'h0 || st_data !== 32'h0 || lsu_bmask !== 3'b000) begin bad++; $display("FAIL reset_lsu got=%h/%h/%b exp=0", lsu_addr, st_data, lsu_bmask); end
    endtask

    task automatic test_load();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h0000_0010; lsu_ld = 32'hDEAD_BEEF;
        @(negedge clk); // cycle 1: ACCESS
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL load_wren got=%b exp=0", wren); end
        total++; if (grant !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL load_grant got=%b busy=%b exp=01 1", grant, busy); end
        total++; if (lsu_addr !== 32'h10) begin bad++; $display("FAIL load_addr got=%h exp=00000010", lsu_addr); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL load_ack_early got=%b exp=0", ack0); end
        @(negedge clk); // cycle 2: RESP
        total++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin bad++; $display("FAIL load_ack got=%b%b exp=01", ack1, ack0); end
        total++; if (rdata0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata0 got=%h exp=deadbeef", rdata0); end
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL load_rdata1 got=%h exp=0", rdata1); end
        req0 = 0;
        @(negedge clk);
        total++; if (ack0 !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL load_idle got ack=%b grant=%b busy=%b exp=0 00 0", ack0, grant, busy); end
    endtask

    task automatic test_both_store();
        do_reset();
        lsu_ld = 32'h5555_AAAA;
        req0 = 1; we0 = 1; addr0 = 32'h1000_0000; wdata0 = 32'h1;
        req1 = 1; we1 = 1; addr1 = 32'h1000_1000; wdata1 = 32'h2;
        @(negedge clk); // cycle 1
        total++; if (grant !== 2'b01 || wren !== 1'b1) begin bad++; $display("FAIL both_c1 got grant=%b wren=%b exp=01 1", grant, wren); end
        total++; if (lsu_addr !== 32'h1000_0000 || st_data !== 32'h1) begin bad++; $display("FAIL both_c1_bus got=%h/%h exp=10000000/1", lsu_addr, st_data); end
        @(negedge clk); // cycle 2
        total++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin bad++; $display("FAIL both_c2_ack got=%b%b exp=01", ack1, ack0); end
        req0 = 0;
        @(negedge clk); // cycle 3
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL both_c3_grant got=%b exp=00", grant); end
        @(negedge clk); // cycle 4
        total++; if (grant !== 2'b10 || wren !== 1'b1) begin bad++; $display("FAIL both_c4 got grant=%b wren=%b exp=10 1", grant, wren); end
        total++; if (lsu_addr !== 32'h1000_1000 || st_data !== 32'h2) begin bad++; $display("FAIL both_c4_bus got=%h/%h exp=10001000/2", lsu_addr, st_data); end
        @(negedge clk); // cycle 5
        total++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin bad++; $display("FAIL both_c5_ack got=%b%b exp=10", ack1, ack0); end
        total++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin bad++; $display("FAIL both_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
        req1 = 0;
        @(negedge clk);
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL both_idle got grant=%b busy=%b exp=00 0", grant, busy); end
    endtask

    task automatic test_rr_hold();
        logic e0, e1, fe0;
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 32'h40; addr1 = 32'h80; lsu_ld = 32'h0000_0077;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e0  = (c == 2) || (c == 8);
            e1  = (c == 5) || (c == 11);
            fe0 = (c % 3) == 2;
            total++; if (ack0 !== e0 || ack1 !== e1) begin bad++; $display("FAIL rr_ack c=%0d got=%b%b exp=%b%b", c, ack1, ack0, e1, e0); end
            total++; if (f_ack0 !== fe0 || f_ack1 !== 1'b0) begin bad++; $display("FAIL fixed_ack c=%0d got=%b%b exp=0%b", c, f_ack1, f_ack0, fe0); end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_word_store();
        int wren_cnt = 0;
        int ack0_cnt = 0;
        int ack1_cnt = 0;
        do_reset();
        req1 = 1; we1 = 1; addr1 = 32'h1000_2000; wdata1 = 32'h0403_0201; bmask1 = 3'b100;
        @(negedge clk); // cycle 1
        total++; if (lsu_bmask !== 3'b100 || grant !== 2'b10) begin bad++; $display("FAIL word_bmask got=%b grant=%b exp=100 10", lsu_bmask, grant); end
        total++; if (lsu_addr !== 32'h1000_2000 || st_data !== 32'h0403_0201) begin bad++; $display("FAIL word_bus got=%h/%h exp=10002000/04030201", lsu_addr, st_data); end
        wren_cnt += int'(wren);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) req1 = 0;
            wren_cnt += int'(wren);
            ack0_cnt += int'(ack0);
            ack1_cnt += int'(ack1);
        end
        total++; if (wren_cnt != 1) begin bad++; $display("FAIL word_wren_cycles got=%0d exp=1", wren_cnt); end
        total++; if (ack1_cnt != 1 || ack0_cnt != 0) begin bad++; $display("FAIL word_acks got ack1=%0d ack0=%0d exp=1 0", ack1_cnt, ack0_cnt); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req0 = 1; we0 = 1; addr0 = 32'h1000_3000; wdata0 = 32'hABCD_0001; bmask0 = 3'b100;
        @(negedge clk); // ACCESS
        total++; if (wren !== 1'b1) begin bad++; $display("FAIL rst_pre_wren got=%b exp=1", wren); end
        #1 rst_n = 0;
        #1;
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL rst_async_wren got=%b exp=0", wren); end
        @(negedge clk);
        total++; if (ack0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_during got ack0=%b busy=%b exp=0 0", ack0, busy); end
        rst_n = 1;
        #1;
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL rst_release got busy=%b grant=%b exp=0 00", busy, grant); end
        @(negedge clk);
        total++; if (grant !== 2'b01 || wren !== 1'b1) begin bad++; $display("FAIL rst_reissue got grant=%b wren=%b exp=01 1", grant, wren); end
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL rst_reissue_ack got=%b exp=1", ack0); end
        req0 = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h20; lsu_ld = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk); // RESP of load
        total++; if (ack0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin bad++; $display("FAIL b2b_load got ack=%b rdata=%h exp=1 12345678", ack0, rdata0); end
        we0 = 1; addr0 = 32'h24; wdata0 = 32'hCAFE_F00D; lsu_ld = 32'hFFFF_FFFF;
        @(negedge clk); // IDLE, store seen
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL b2b_gap_ack got=%b exp=0", ack0); end
        @(negedge clk); // ACCESS store
        total++; if (wren !== 1'b1 || lsu_addr !== 32'h24 || st_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_store got wren=%b addr=%h data=%h exp=1 24 cafef00d", wren, lsu_addr, st_data); end
        @(negedge clk); // RESP store
        total++; if (ack0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin bad++; $display("FAIL b2b_store_ack got ack=%b rdata=%h exp=1 12345678", ack0, rdata0); end
        req0 = 0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bmask0 = '0; bmask1 = '0; lsu_ld = '0;
        test_reset();
        test_load();
        test_both_store();
        test_rr_hold();
        test_word_store();
        test_reset_mid_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
